// File: rtl/pipe_buf.sv
// pipe_buf: registered inter-stage pipeline buffer.
// Upstream writes with a level request (buf_we) and gets a one-cycle buf_wack.
// Downstream reads with a level request (buf_re) and gets a one-cycle buf_rack,
// with the packet held on buf_dout. A synchronous flush drops every stored entry.
module pipe_buf #(
   parameter int WIDTH = 96,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             buf_we,
   input  logic [WIDTH-1:0] buf_din,
   output logic             buf_wack,
   output logic             buf_full,
   output logic             buf_avail,
   input  logic             buf_re,
   output logic             buf_rack,
   output logic [WIDTH-1:0] buf_dout
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic             wr_acc;
   logic             rd_acc;

   // Accept decisions use the pre-edge count; a high ack blocks its own side
   // for one cycle, and flush blocks both sides.
   always_comb begin
      wr_acc = buf_we & ~buf_wack & (cnt != CNT_MAX) & ~flush;
      rd_acc = buf_re & ~buf_rack & (cnt != '0) & ~flush;
      if (flush) begin
         cnt_nxt = '0;
      end else begin
         cnt_nxt = cnt + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
      end
   end

   // Payload storage; contents are don't-care after reset or flush.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wp] <= buf_din;
      end
   end

   // Pointers, count, acks and registered status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp        <= '0;
         rp        <= '0;
         cnt       <= '0;
         buf_wack  <= 1'b0;
         buf_rack  <= 1'b0;
         buf_avail <= 1'b0;
         buf_full  <= 1'b0;
         buf_dout  <= '0;
      end else begin
         cnt       <= cnt_nxt;
         buf_avail <= (cnt_nxt != '0);
         buf_full  <= (cnt_nxt == CNT_MAX);
         buf_wack  <= wr_acc;
         buf_rack  <= rd_acc;
         if (flush) begin
            wp <= '0;
            rp <= '0;
         end else begin
            if (wr_acc) begin
               wp <= wp + AW'(1);
            end
            if (rd_acc) begin
               rp       <= rp + AW'(1);
               buf_dout <= mem[rp];
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_buf.sv
// tb_pipe_buf: directed-vector bench for pipe_buf (WIDTH=96, DEPTH=2).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_pipe_buf;

   localparam int W = 96;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic         buf_we = 1'b0;
   logic [W-1:0] buf_din = '0;
   logic         buf_wack;
   logic         buf_full;
   logic         buf_avail;
   logic         buf_re = 1'b0;
   logic         buf_rack;
   logic [W-1:0] buf_dout;

   int n_vec = 0;
   int n_err = 0;

   pipe_buf #(.WIDTH(W), .DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .buf_we    (buf_we),
      .buf_din   (buf_din),
      .buf_wack  (buf_wack),
      .buf_full  (buf_full),
      .buf_avail (buf_avail),
      .buf_re    (buf_re),
      .buf_rack  (buf_rack),
      .buf_dout  (buf_dout)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check the four control outputs at once.
   task automatic flags(input string tag, input logic wack, input logic rack,
                        input logic avail, input logic full);
      check({tag, ".wack"},  W'(buf_wack),  W'(wack));
      check({tag, ".rack"},  W'(buf_rack),  W'(rack));
      check({tag, ".avail"}, W'(buf_avail), W'(avail));
      check({tag, ".full"},  W'(buf_full),  W'(full));
   endtask

   // Full two-cycle write handshake: request, ack cycle with request dropped.
   task automatic wr(input logic [W-1:0] d);
      buf_we = 1'b1; buf_din = d;
      step();
      check("wr.wack", W'(buf_wack), W'(1));
      buf_we = 1'b0;
      step();
   endtask

   initial begin
      // Reset
      step(); step();
      flags("rst", 0, 0, 0, 0);
      check("rst.dout", buf_dout, '0);
      rst = 1'b0;
      step();
      flags("idle", 0, 0, 0, 0);

      // Single write then read
      buf_we = 1'b1; buf_din = W'(96'h1234);
      step();
      flags("t1.w", 1, 0, 1, 0);
      buf_we = 1'b0;
      step();
      flags("t1.wd", 0, 0, 1, 0);
      buf_re = 1'b1;
      step();
      flags("t1.r", 0, 1, 0, 0);
      check("t1.dout", buf_dout, W'(96'h1234));
      buf_re = 1'b0;
      step();
      flags("t1.rd", 0, 0, 0, 0);

      // Fill, blocked write, pointer wrap
      wr(W'(96'hA));
      wr(W'(96'hB));
      flags("t2.full", 0, 0, 1, 1);
      buf_we = 1'b1; buf_din = W'(96'hC);
      step();
      flags("t2.blk1", 0, 0, 1, 1);
      step();
      flags("t2.blk2", 0, 0, 1, 1);
      buf_re = 1'b1;
      step();
      flags("t2.rA", 0, 1, 1, 0);
      check("t2.doutA", buf_dout, W'(96'hA));
      buf_re = 1'b0;
      step();
      flags("t2.wC", 1, 0, 1, 1);
      buf_we = 1'b0;
      step();
      buf_re = 1'b1;
      step();
      flags("t2.rB", 0, 1, 1, 0);
      check("t2.doutB", buf_dout, W'(96'hB));
      buf_re = 1'b0;
      step();
      buf_re = 1'b1;
      step();
      flags("t2.rC", 0, 1, 0, 0);
      check("t2.doutC", buf_dout, W'(96'hC));
      buf_re = 1'b0;
      step();

      // Read held on empty, then write lands
      buf_re = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t3.norack", W'(buf_rack), W'(0));
      end
      buf_we = 1'b1; buf_din = W'(96'hBEEF);
      step();
      flags("t3.w", 1, 0, 1, 0);
      buf_we = 1'b0;
      step();
      flags("t3.r", 0, 1, 0, 0);
      check("t3.dout", buf_dout, W'(96'hBEEF));
      buf_re = 1'b0;
      step();

      // Simultaneous read and write with one entry stored
      wr(W'(96'h1111));
      buf_we = 1'b1; buf_din = W'(96'h2222); buf_re = 1'b1;
      step();
      flags("t4.both", 1, 1, 1, 0);
      check("t4.doutX", buf_dout, W'(96'h1111));
      buf_we = 1'b0; buf_re = 1'b0;
      step();
      buf_re = 1'b1;
      step();
      flags("t4.rY", 0, 1, 0, 0);
      check("t4.doutY", buf_dout, W'(96'h2222));
      buf_re = 1'b0;
      step();

      // Flush with two entries and a same-cycle write
      wr(W'(96'h3333));
      wr(W'(96'h4444));
      buf_we = 1'b1; buf_din = W'(96'h5555); flush = 1'b1;
      step();
      flags("t5.fl", 0, 0, 0, 0);
      check("t5.dkeep", buf_dout, W'(96'h2222));
      flush = 1'b0;
      step();
      flags("t5.w", 1, 0, 1, 0);
      buf_we = 1'b0;
      step();
      buf_re = 1'b1;
      step();
      flags("t5.r", 0, 1, 0, 0);
      check("t5.dout", buf_dout, W'(96'h5555));
      buf_re = 1'b0;
      step();
      buf_re = 1'b1;
      step(); step();
      check("t5.empty", W'(buf_rack), W'(0));
      buf_re = 1'b0;
      step();

      // Flush with one entry blocks a same-cycle read and write
      wr(W'(96'h7777));
      buf_we = 1'b1; buf_din = W'(96'h8888); buf_re = 1'b1; flush = 1'b1;
      step();
      flags("t6.fl", 0, 0, 0, 0);
      check("t6.dkeep", buf_dout, W'(96'h5555));
      buf_we = 1'b0; buf_re = 1'b0; flush = 1'b0;
      step();

      // Asynchronous reset between edges with a pending write
      wr(W'(96'h9999));
      buf_re = 1'b1;
      step();
      check("t7.pre", buf_dout, W'(96'h9999));
      buf_re = 1'b0;
      wr(W'(96'hAAAA));
      buf_we = 1'b1; buf_din = W'(96'h6666);
      #2 rst = 1'b1;
      #1;
      flags("t7.async", 0, 0, 0, 0);
      check("t7.dout", buf_dout, '0);
      buf_we = 1'b0;
      step();
      rst = 1'b0;
      step();
      flags("t7.after", 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
